// File: rtl/ta_ldd_cmd_parser.sv
// ta_ldd_cmd_parser
//   Host-side command front end for the LDD pulse generator. Receives
//   fixed 8-byte frames (5A, OP, WD, PL[31:24..7:0], CHK) on a byte
//   valid/ready stream. It validates each frame, holds the command-path and
//   capture-path control registers, and drives the pulse stage strobes.
//
// Ports
//   clk200            : 200 MHz clock, all logic on the rising edge
//   rst               : synchronous reset, active low
//   rx_data/rx_valid  : incoming command byte
//   rx_ready          : byte accepted when rx_valid && rx_ready
//   capr_rdy          : capture path ready, from the pulse stage
//   cap_mode          : 1 = capture path active, 0 = command path active
//   cap_wdis/cap_plus : capture window select / pulse count
//   cap_trig          : 1-cycle capture trigger
//   com_wdis/com_plus : command window select / pulse count
//   com_open/close    : 1-cycle command strobes
//   ack / err         : 1-cycle per-frame status pulses
//   err_code          : last error code (1 chk, 2 opcode, 3 busy, 4 timeout, 5 range)
//   frame_cnt         : count of successfully executed frames (wraps)
module ta_ldd_cmd_parser #(
  parameter int TOP0_0  = 3,
  parameter int LDD0_0  = 32,
  parameter int TIMEOUT = 2000
) (
  input  logic              clk200,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              capr_rdy,
  output logic              cap_mode,
  output logic [TOP0_0-1:0] cap_wdis,
  output logic [LDD0_0-1:0] cap_plus,
  output logic              cap_trig,
  output logic [TOP0_0-1:0] com_wdis,
  output logic [LDD0_0-1:0] com_plus,
  output logic              com_open,
  output logic              com_close,
  output logic              ack,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [15:0]       frame_cnt
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0] HDR      = 8'h5A;
  localparam logic [7:0] OP_OPEN  = 8'h01;
  localparam logic [7:0] OP_CLOSE = 8'h02;
  localparam logic [7:0] OP_ARM   = 8'h03;
  localparam logic [7:0] OP_MODE  = 8'h04;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CHK   = 3'd1;
  localparam logic [2:0] ERR_OP    = 3'd2;
  localparam logic [2:0] ERR_BUSY  = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;
  localparam logic [2:0] ERR_RANGE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_EXEC
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        wd_q, wd_d;
  logic [31:0]       pl_q, pl_d;
  logic [7:0]        chk_q, chk_d;

  // Result of the CHECK cycle, consumed by EXEC.
  logic [2:0]        pend_op_q, pend_op_d;
  logic [2:0]        pend_code_q, pend_code_d;

  logic              cap_mode_q, cap_mode_d;
  logic [TOP0_0-1:0] cap_wdis_q, cap_wdis_d;
  logic [LDD0_0-1:0] cap_plus_q, cap_plus_d;
  logic [TOP0_0-1:0] com_wdis_q, com_wdis_d;
  logic [LDD0_0-1:0] com_plus_q, com_plus_d;
  logic              cap_trig_q, cap_trig_d;
  logic              com_open_q, com_open_d;
  logic              com_close_q, com_close_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              accept;
  logic [7:0]        chk_calc;
  logic [2:0]        frame_code;

  // Reset gates rx_ready directly so nothing is taken while rst is low.
  assign rx_ready = rst && ((state_q == ST_IDLE) || (state_q == ST_RECV));
  assign accept   = rx_valid && rx_ready;

  assign chk_calc = op_q ^ wd_q ^ pl_q[31:24] ^ pl_q[23:16] ^ pl_q[15:8] ^ pl_q[7:0];

  // Error classification; earlier tests take priority over later ones.
  always_comb begin
    frame_code = ERR_NONE;
    if (chk_calc != chk_q) begin
      frame_code = ERR_CHK;
    end else if ((op_q == 8'd0) || (op_q > OP_MODE)) begin
      frame_code = ERR_OP;
    end else if (((op_q == OP_OPEN) || (op_q == OP_ARM)) && ((wd_q >> TOP0_0) != 8'd0)) begin
      frame_code = ERR_RANGE;
    end else if ((op_q == OP_ARM) && !capr_rdy) begin
      frame_code = ERR_BUSY;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    op_d        = op_q;
    wd_d        = wd_q;
    pl_d        = pl_q;
    chk_d       = chk_q;
    pend_op_d   = pend_op_q;
    pend_code_d = pend_code_q;
    cap_mode_d  = cap_mode_q;
    cap_wdis_d  = cap_wdis_q;
    cap_plus_d  = cap_plus_q;
    com_wdis_d  = com_wdis_q;
    com_plus_d  = com_plus_q;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    cap_trig_d  = 1'b0;
    com_open_d  = 1'b0;
    com_close_d = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Anything other than a header byte is swallowed as line noise.
        if (accept && (rx_data == HDR)) begin
          state_d = ST_RECV;
          idx_d   = 3'd1;
          gap_d   = '0;
        end
      end

      ST_RECV: begin
        if (accept) begin
          gap_d = '0;
          case (idx_q)
            3'd1:    op_d         = rx_data;
            3'd2:    wd_d         = rx_data;
            3'd3:    pl_d[31:24]  = rx_data;
            3'd4:    pl_d[23:16]  = rx_data;
            3'd5:    pl_d[15:8]   = rx_data;
            3'd6:    pl_d[7:0]    = rx_data;
            3'd7:    chk_d        = rx_data;
            default: ;
          endcase
          if (idx_q == 3'd7) begin
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (gap_q == GAP_W'(TIMEOUT)) begin
          // A byte arriving on this very cycle would have been taken above.
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_CHECK: begin
        // Data registers update here so they lead their strobe by a cycle.
        pend_op_d   = op_q[2:0];
        pend_code_d = frame_code;
        if (frame_code == ERR_NONE) begin
          case (op_q)
            OP_OPEN: begin
              com_wdis_d = wd_q[TOP0_0-1:0];
              com_plus_d = pl_q[LDD0_0-1:0];
            end
            OP_ARM: begin
              cap_wdis_d = wd_q[TOP0_0-1:0];
              cap_plus_d = pl_q[LDD0_0-1:0];
            end
            OP_MODE: cap_mode_d = wd_q[0];
            default: ;
          endcase
        end
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (pend_code_q == ERR_NONE) begin
          ack_d       = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          case (pend_op_q)
            OP_OPEN[2:0]:  com_open_d  = 1'b1;
            OP_CLOSE[2:0]: com_close_d = 1'b1;
            OP_ARM[2:0]:   cap_trig_d  = 1'b1;
            default: ;
          endcase
        end else begin
          err_d      = 1'b1;
          err_code_d = pend_code_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk200) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      op_q        <= '0;
      wd_q        <= '0;
      pl_q        <= '0;
      chk_q       <= '0;
      pend_op_q   <= '0;
      pend_code_q <= '0;
      cap_mode_q  <= 1'b0;
      cap_wdis_q  <= '0;
      cap_plus_q  <= '0;
      com_wdis_q  <= '0;
      com_plus_q  <= '0;
      cap_trig_q  <= 1'b0;
      com_open_q  <= 1'b0;
      com_close_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      op_q        <= op_d;
      wd_q        <= wd_d;
      pl_q        <= pl_d;
      chk_q       <= chk_d;
      pend_op_q   <= pend_op_d;
      pend_code_q <= pend_code_d;
      cap_mode_q  <= cap_mode_d;
      cap_wdis_q  <= cap_wdis_d;
      cap_plus_q  <= cap_plus_d;
      com_wdis_q  <= com_wdis_d;
      com_plus_q  <= com_plus_d;
      cap_trig_q  <= cap_trig_d;
      com_open_q  <= com_open_d;
      com_close_q <= com_close_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cap_mode  = cap_mode_q;
  assign cap_wdis  = cap_wdis_q;
  assign cap_plus  = cap_plus_q;
  assign cap_trig  = cap_trig_q;
  assign com_wdis  = com_wdis_q;
  assign com_plus  = com_plus_q;
  assign com_open  = com_open_q;
  assign com_close = com_close_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ta_ldd_cmd_parser.sv
// Directed testbench for ta_ldd_cmd_parser. Inputs change and outputs are
// sampled 1 time unit after the rising clock edge.
module tb_ta_ldd_cmd_parser;

  localparam int TOP = 3;
  localparam int LDD = 32;
  localparam int TMO = 2000;

  logic           clk200 = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic           capr_rdy;
  logic           cap_mode;
  logic [TOP-1:0] cap_wdis;
  logic [LDD-1:0] cap_plus;
  logic           cap_trig;
  logic [TOP-1:0] com_wdis;
  logic [LDD-1:0] com_plus;
  logic           com_open;
  logic           com_close;
  logic           ack;
  logic           err;
  logic [2:0]     err_code;
  logic [15:0]    frame_cnt;

  always #5 clk200 = ~clk200;

  ta_ldd_cmd_parser #(.TOP0_0(TOP), .LDD0_0(LDD), .TIMEOUT(TMO)) dut (
    .clk200    (clk200),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .capr_rdy  (capr_rdy),
    .cap_mode  (cap_mode),
    .cap_wdis  (cap_wdis),
    .cap_plus  (cap_plus),
    .cap_trig  (cap_trig),
    .com_wdis  (com_wdis),
    .com_plus  (com_plus),
    .com_open  (com_open),
    .com_close (com_close),
    .ack       (ack),
    .err       (err),
    .err_code  (err_code),
    .frame_cnt (frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters, sampled on the falling edge.
  int err_seen = 0, open_seen = 0, close_seen = 0, trig_seen = 0, ack_seen = 0, multi_hot = 0;

  always @(negedge clk200) begin
    if (err)       err_seen++;
    if (com_open)  open_seen++;
    if (com_close) close_seen++;
    if (cap_trig)  trig_seen++;
    if (ack)       ack_seen++;
    if ($countones({err, com_open, com_close, cap_trig}) > 1) multi_hot++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk200);
    #1;
  endtask

  // Present one byte, wait for its acceptance edge, then idle gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      step();
      n++;
    end
    if (!rx_ready) check_val("rx_ready_wait", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Send B0..B7 (B0 in the top byte); returns 1 unit after B7's edge N.
  task automatic send_frame(input logic [63:0] f, input int gap);
    for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8], (i > 0) ? gap : 0);
  endtask

  int e0, o0, c0, t0, a0, k;

  initial begin
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    capr_rdy = 1'b0;
    repeat (3) step();

    // Reset state
    check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("rst_err_code", 32'(err_code), 32'd0);
    check_val("rst_outputs", 32'({cap_mode, cap_trig, com_open, com_close, ack, err}), 32'd0);
    rst = 1'b1;
    #1;
    check_val("rel_rx_ready", 32'(rx_ready), 32'd1);
    step();

    // OPEN, back-to-back, with cycle-exact latency
    send_frame(64'h5A01_0500_0001_F4F1, 0);
    check_val("open_N_rx_ready", 32'(rx_ready), 32'd0);
    check_val("open_N_com_plus", com_plus, 32'd0);
    step();
    check_val("open_N1_com_wdis", 32'(com_wdis), 32'd5);
    check_val("open_N1_com_plus", com_plus, 32'd500);
    check_val("open_N1_com_open", 32'(com_open), 32'd0);
    check_val("open_N1_rx_ready", 32'(rx_ready), 32'd0);
    step();
    check_val("open_N2_strobes", 32'({com_open, ack, err}), 32'b110);
    check_val("open_N2_frame_cnt", 32'(frame_cnt), 32'd1);
    check_val("open_N2_rx_ready", 32'(rx_ready), 32'd1);
    step();
    check_val("open_N3_strobes", 32'({com_open, ack}), 32'd0);

    // ARM accepted
    capr_rdy = 1'b1;
    send_frame(64'h5A03_0200_0000_6465, 0);
    step();
    check_val("arm_cap_wdis", 32'(cap_wdis), 32'd2);
    check_val("arm_cap_plus", cap_plus, 32'd100);
    check_val("arm_N1_trig", 32'(cap_trig), 32'd0);
    step();
    check_val("arm_N2_trig_ack", 32'({cap_trig, ack}), 32'b11);
    check_val("arm_frame_cnt", 32'(frame_cnt), 32'd2);
    step();
    check_val("arm_N3_trig", 32'(cap_trig), 32'd0);

    // ARM while capture busy (different payload, must not load)
    capr_rdy = 1'b0;
    t0 = trig_seen;
    send_frame(64'h5A03_0100_0000_C8CA, 0);
    step();
    step();
    check_val("busy_err", 32'({err, ack}), 32'b10);
    check_val("busy_code", 32'(err_code), 32'd3);
    step();
    check_val("busy_cap_plus", cap_plus, 32'd100);
    check_val("busy_cap_wdis", 32'(cap_wdis), 32'd2);
    check_val("busy_no_trig", 32'(trig_seen - t0), 32'd0);
    capr_rdy = 1'b1;

    // Checksum error
    o0 = open_seen;
    send_frame(64'h5A01_0500_0001_F4F0, 0);
    step();
    step();
    check_val("chk_err", 32'(err), 32'd1);
    check_val("chk_code", 32'(err_code), 32'd1);
    step();
    check_val("chk_no_open", 32'(open_seen - o0), 32'd0);

    // Unknown opcode
    send_frame(64'h5A07_0000_0000_0007, 0);
    step();
    step();
    check_val("op_code", 32'({err, err_code}), 32'b1010);

    // Range error on WD
    send_frame(64'h5A01_0800_0000_0009, 0);
    step();
    step();
    check_val("range_code", 32'({err, err_code}), 32'b1101);
    check_val("range_com_wdis", 32'(com_wdis), 32'd5);
    check_val("err_frame_cnt", 32'(frame_cnt), 32'd2);

    // Noise, then CLOSE with 1-cycle gaps
    c0 = close_seen;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5B, 0);
    send_frame(64'h5A02_0000_0000_0002, 1);
    step();
    step();
    check_val("close_pulse", 32'({com_close, ack}), 32'b11);
    repeat (3) step();
    check_val("close_count", 32'(close_seen - c0), 32'd1);
    check_val("close_frame_cnt", 32'(frame_cnt), 32'd3);

    // Timeout after 5A 04
    send_byte(8'h5A, 0);
    send_byte(8'h04, 0);
    k = 0;
    while (!err && k < TMO + 100) begin
      step();
      k++;
    end
    check_val("tmo_latency", 32'(k), 32'(TMO + 1));
    check_val("tmo_code", 32'(err_code), 32'd4);
    step();
    check_val("tmo_err_clear", 32'(err), 32'd0);
    send_frame(64'h5A04_0100_0000_0005, 0);
    step();
    check_val("mode_cap_mode", 32'(cap_mode), 32'd1);
    step();
    check_val("mode_ack", 32'(ack), 32'd1);
    check_val("mode_frame_cnt", 32'(frame_cnt), 32'd4);
    step();

    // Byte arriving on the cycle the gap count hits TIMEOUT is taken
    e0 = err_seen;
    send_byte(8'h5A, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, TMO);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    step();
    step();
    check_val("edge_ack", 32'(ack), 32'd1);
    check_val("edge_cap_mode", 32'(cap_mode), 32'd0);
    check_val("edge_no_err", 32'(err_seen - e0), 32'd0);
    check_val("edge_frame_cnt", 32'(frame_cnt), 32'd5);
    step();

    // Reset after B4 of an OPEN frame
    o0 = open_seen;
    a0 = ack_seen;
    send_byte(8'h5A, 0);
    send_byte(8'h01, 0);
    send_byte(8'h06, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rst = 1'b0;
    step();
    step();
    check_val("mrst_rx_ready", 32'(rx_ready), 32'd0);
    check_val("mrst_data", 32'({cap_mode, cap_wdis, com_wdis}), 32'd0);
    check_val("mrst_plus", cap_plus | com_plus, 32'd0);
    check_val("mrst_cnt_code", 32'({frame_cnt, err_code}), 32'd0);
    rst = 1'b1;
    step();
    send_byte(8'h01, 0);
    send_byte(8'hF4, 0);
    send_byte(8'hF1, 0);
    repeat (4) step();
    check_val("mrst_no_open", 32'(open_seen - o0), 32'd0);
    check_val("mrst_no_ack", 32'(ack_seen - a0), 32'd0);
    check_val("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("mrst_com_wdis", 32'(com_wdis), 32'd0);

    check_val("strobe_onehot", 32'(multi_hot), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ta_ldd_cmd_parser.md
Name: ta_ldd_cmd_parser

Overview:
- Host-side command front end for the LDD pulse generator.
- Accepts fixed 8-byte command frames on a byte-stream valid/ready interface, validates them, and holds the command-path and capture-path control registers.
- Drives the LDD pulse stage's inputs directly: cap_mode, cap_wdis/cap_plus/cap_trig, com_wdis/com_plus/com_open/com_close.
- Reports per-frame status (ack or error).

Parameters:
- TOP0_0, 3: width of the wdis window select.
- LDD0_0, 32: width of the pulse-count field (payload carries up to 32 bits).
- TIMEOUT, 2000: max idle cycles between bytes inside a frame (10 us at 200 MHz).

Ports:
- clk200, input, 1: 200 MHz clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-low reset.
- rx_data, input, 8: command byte.
- rx_valid, input, 1: rx_data valid.
- rx_ready, output, 1: byte accepted when rx_valid && rx_ready.
- capr_rdy, input, 1: capture path ready, from the pulse stage.
- cap_mode, output, 1: 1 = capture path active, 0 = command path active.
- cap_wdis, output, TOP0_0: capture window select.
- cap_plus, output, LDD0_0: capture pulse count.
- cap_trig, output, 1: 1-cycle capture trigger.
- com_wdis, output, TOP0_0: command window select.
- com_plus, output, LDD0_0: command pulse count.
- com_open, output, 1: 1-cycle open strobe.
- com_close, output, 1: 1-cycle close strobe.
- ack, output, 1: 1-cycle pulse on successful execution.
- err, output, 1: 1-cycle pulse on frame rejection.
- err_code, output, 3: code of the last error, held until the next error.
- frame_cnt, output, 16: count of successful frames; wraps at 0xFFFF→0.

Behaviour:
- Frame layout, big-endian: B0 = 0x5A header, B1 = OP, B2 = WD, B3..B6 = PL[31:0], B7 = CHK.
- CHK = XOR of B1..B6. PL is truncated to LDD0_0 bits.
- Opcodes:
  - 0x01 OPEN: load com_wdis/com_plus, then pulse com_open.
  - 0x02 CLOSE: pulse com_close; payload ignored.
  - 0x03 ARM: load cap_wdis/cap_plus, then pulse cap_trig.
  - 0x04 MODE: cap_mode <= WD[0].
- States:
  - IDLE: rx_ready=1. A non-0x5A byte is consumed and discarded. 0x5A → RECV with byte index=1.
  - RECV: rx_ready=1. Store the byte at the current index. After B7 → CHECK. Inside a frame, 0x5A is ordinary data.
  - CHECK: rx_ready=0, one cycle. Validate, and load data registers if valid → EXEC.
  - EXEC: rx_ready=0, one cycle. Assert the strobe plus ack (or err) → IDLE.
- Latency, with B7 accepted on edge N:
  - Data registers (com_*/cap_wdis/cap_plus/cap_mode) change at edge N+1.
  - Strobes, ack, err and the frame_cnt increment are visible after edge N+2, high for exactly one cycle.
  - Data is therefore stable ≥1 cycle before its strobe.
  - Next frame byte accepted at edge N+3 at the earliest.
- Error checks, evaluated in this priority order:
  - 1: checksum mismatch.
  - 2: unknown opcode (0x00 or ≥0x05).
  - 5: range — WD has bits set at or above TOP0_0 (OPEN/ARM only).
  - 3: busy — ARM while capr_rdy=0, sampled in CHECK.
- On any error: no data register changes, no strobe, err pulse in EXEC, err_code updated, frame_cnt unchanged.
- Timeout:
  - Gap counter clears on every accepted byte in RECV and increments otherwise.
  - When it reaches TIMEOUT: → IDLE, err pulse, err_code=4, partial frame dropped.
  - A byte arriving in the same cycle the count reaches TIMEOUT is accepted and the timeout is cancelled.
- Reset (rst=0 at an edge, including mid-frame):
  - State=IDLE, rx_ready=0 during reset.
  - All outputs 0: cap_mode=0, com_*/cap_* data=0, strobes/ack/err=0, err_code=0, frame_cnt=0.
  - rx_ready=1 on the first cycle after rst returns to 1.
- At most one of com_open, com_close, cap_trig, err is high in any cycle.

Test Plan:
- OPEN: reset, then send 5A 01 05 00 00 01 F4 F1 back-to-back.
  → com_wdis=5 and com_plus=500 one cycle after B7.
  → com_open and ack high 1 cycle, the cycle after that.
  → frame_cnt=1, rx_ready low for exactly 2 cycles.
- ARM: hold capr_rdy=1, send 5A 03 02 00 00 00 64 65.
  → cap_wdis=2, cap_plus=100, then a 1-cycle cap_trig.
  → Repeat with capr_rdy=0: no cap_trig, err pulse, err_code=3, cap_plus unchanged.
- Frame errors: send OPEN with CHK=F0 → err_code=1, com_open never rises.
  → Send OP=07 with a correct CHK → err_code=2.
  → Send WD=08 (OPEN, TOP0_0=3, CHK fixed up) → err_code=5.
- Gap and noise: prepend noise bytes 00 FF 5B, then send a valid CLOSE frame with 1-cycle rx_valid gaps.
  → Noise discarded, single com_close pulse, frame_cnt increments by 1.
- Timeout: send 5A 04, then idle 2000 cycles.
  → err pulse with err_code=4, back in IDLE.
  → A following 5A 04 01 00 00 00 00 05 sets cap_mode=1.
- Reset mid-frame: assert rst=0 after B4 of an OPEN frame.
  → All outputs 0, no strobe.
  → The remaining bytes B5..B7 sent after reset are discarded as noise.
  → frame_cnt stays 0.
